i2s_tx_stereo: RTL

//  Parametrised stereo I2S transmitter; successor to the fixed 16-bit mono i2s

---
 rtl/i2s_tx_stereo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo
// Stereo Philips-I2S transmitter. Left/right sample pairs enter a small frame
// FIFO over a valid/ready handshake; the block derives mclk, sclk and lrclk
// from the system clock and shifts each frame out MSB-first, one bit after
// every lrclk edge, zero-padded to the slot length. A frame start that finds
// the FIFO empty sends silence and raises a one-clock underrun pulse.
module i2s_tx_stereo #(
  parameter int WIDTH     = 16,  // bits per sample, 1 .. SLOT-1
  parameter int SLOT      = 32,  // sclk periods per channel slot
  parameter int SCLK_HALF = 2,   // clk cycles per sclk half-period
  parameter int DEPTH     = 4    // FIFO depth in frames, power of 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_left,
  input  logic [WIDTH-1:0]           in_right,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underrun,
  output logic                       mclk,
  output logic                       sclk,
  output logic                       lrclk,
  output logic                       sdin
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = 2 * WIDTH;

  localparam logic [CW-1:0] CNT_MAX  = CW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Clock generation state
  logic          r_mclk;
  logic          r_sclk;
  logic [CW-1:0] r_cnt;

  // Serialiser state
  logic [BW-1:0] r_bitcnt;
  logic          r_lrclk;
  logic          r_sdin;
  logic          r_underrun;
  logic [FW-1:0] r_frame;    // {left, right} of the frame in flight

  // Frame FIFO
  logic [FW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_wrap;
  logic          w_fall;
  logic          w_frame_start;
  logic [BW-1:0] w_bit_next;
  logic [BW-1:0] w_slot_pos;
  logic [WIDTH-1:0] w_sample;
  logic          w_sdin_next;
  logic          w_in_ready;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_wrap        = (r_cnt == CNT_MAX);
  assign w_fall        = w_wrap && r_sclk;
  assign w_frame_start = w_fall && (r_bitcnt == BIT_MAX);
  assign w_bit_next    = (r_bitcnt == BIT_MAX) ? '0 : r_bitcnt + BW'(1);

  assign w_in_ready = (r_level != LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push     = in_valid && w_in_ready;
  // A pop is only ever requested by a frame start that finds data waiting.
  assign w_pop      = w_frame_start && !w_empty;

  // Bit position within the slot that the coming falling edge will present.
  assign w_slot_pos = (w_bit_next >= SLOT_LEN) ? w_bit_next - SLOT_LEN : w_bit_next;
  // Position 0 of a slot always carries the delay bit (0), so at a frame start
  // the stale r_frame contents are never looked at and r_frame can be used here.
  assign w_sample   = (w_bit_next < SLOT_LEN) ? r_frame[FW-1 -: WIDTH] : r_frame[WIDTH-1:0];

  // Pick the MSB-first data bit for slot positions 1..WIDTH, zero elsewhere
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_sdin_next = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      if (w_slot_pos == BW'(k)) w_sdin_next = w_sample[WIDTH-k];
    end
  end

  // mclk runs at half the system clock
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_mclk <= 1'b0;
    else       r_mclk <= ~r_mclk;
  end

  // sclk divider: toggle sclk every SCLK_HALF clk cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) r_sclk <= ~r_sclk;
    end
  end

  // Bit counter, lrclk and serial data advance on falling sclk edges only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt <= BIT_MAX;
      r_lrclk  <= 1'b1;
      r_sdin   <= 1'b0;
    end else if (w_fall) begin
      r_bitcnt <= w_bit_next;
      r_lrclk  <= (w_bit_next >= SLOT_LEN);
      r_sdin   <= w_sdin_next;
    end
  end

  // Frame register: latch the FIFO head (or silence) at each frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start && w_empty;
      if (w_frame_start) r_frame <= w_pop ? r_mem[r_rd_ptr] : '0;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; entries are only read after being
    // written, and the level counter alone defines which entries are valid.
    if (w_push) r_mem[r_wr_ptr] <= {in_left, in_right};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign level    = r_level;
  assign underrun = r_underrun;
  assign mclk     = r_mclk;
  assign sclk     = r_sclk;
  assign lrclk    = r_lrclk;
  assign sdin     = r_sdin;

endmodule
